// File: rtl/led_pattern_decoder_if.sv
// Signal bundle between the LED lines / tick source and the pattern decoder.
// tick is a one-clk strobe with no back-pressure; pulses on the outputs are single-clk.
interface led_pattern_decoder_if;
  logic       tick;
  logic       led_a;
  logic       led_b;
  logic [1:0] state;
  logic       state_valid;
  logic       state_change;
  logic       pattern_err;
  logic       locked_dbg;

  modport master (
    output tick, led_a, led_b,
    input  state, state_valid, state_change, pattern_err, locked_dbg
  );

  modport slave (
    input  tick, led_a, led_b,
    output state, state_valid, state_change, pattern_err, locked_dbg
  );
endinterface

// File: rtl/led_pattern_decoder.sv
// Classifies windows of ticked LED samples into four 2-bit states and publishes
// a state once the same class has been seen in CONFIRM consecutive windows.
module led_pattern_decoder #(
  parameter int WINDOW  = 4,
  parameter int CONFIRM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_pattern_decoder_if.slave  bus
);

  localparam int CW = $clog2(WINDOW);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} fsm_t;

  logic a_s1, a_s2, b_s1, b_s2;
  logic [CW-1:0] cnt;
  logic a0, b0, a_prev, b_prev;
  logic a_const, b_const, a_tog, b_tog, in_ph, anti_ph;
  logic a0_n, b0_n, a_const_n, b_const_n, a_tog_n, b_tog_n, in_n, anti_n;
  logic first, last, win_done;
  logic [1:0] cls;
  logic cls_ok;

  fsm_t fsm, fsm_n;
  logic [1:0] cand, cand_n, state_r, state_n;
  logic [3:0] conf, conf_n, conf_inc, inv, inv_n;
  logic change_r, change_n, err_r, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= bus.led_a;
      a_s2 <= a_s1;
      b_s1 <= bus.led_b;
      b_s2 <= b_s1;
    end
  end

  assign first    = (cnt == '0);
  assign last     = (cnt == CW'(WINDOW - 1));
  assign win_done = bus.tick & last;

  // Flag values including the current sample, so the last tick classifies itself
  always_comb begin
    a0_n      = a0;
    b0_n      = b0;
    a_const_n = a_const & (a_s2 == a_prev);
    b_const_n = b_const & (b_s2 == b_prev);
    a_tog_n   = a_tog & (a_s2 != a_prev);
    b_tog_n   = b_tog & (b_s2 != b_prev);
    in_n      = in_ph & (a_s2 == b_s2);
    anti_n    = anti_ph & (a_s2 != b_s2);
    if (first) begin
      a0_n      = a_s2;
      b0_n      = b_s2;
      a_const_n = 1'b1;
      b_const_n = 1'b1;
      a_tog_n   = 1'b1;
      b_tog_n   = 1'b1;
      in_n      = (a_s2 == b_s2);
      anti_n    = (a_s2 != b_s2);
    end
  end

  always_comb begin
    cls    = 2'd0;
    cls_ok = 1'b0;
    if (a_const_n & b_const_n & ~b0_n) begin
      cls    = {1'b0, a0_n};
      cls_ok = 1'b1;
    end else if (a_tog_n & b_tog_n & anti_n) begin
      cls    = 2'd2;
      cls_ok = 1'b1;
    end else if (a_tog_n & b_tog_n & in_n) begin
      cls    = 2'd3;
      cls_ok = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a0      <= 1'b0;
      b0      <= 1'b0;
      a_prev  <= 1'b0;
      b_prev  <= 1'b0;
      a_const <= 1'b0;
      b_const <= 1'b0;
      a_tog   <= 1'b0;
      b_tog   <= 1'b0;
      in_ph   <= 1'b0;
      anti_ph <= 1'b0;
    end else if (bus.tick) begin
      cnt     <= last ? '0 : cnt + CW'(1);
      a0      <= a0_n;
      b0      <= b0_n;
      a_prev  <= a_s2;
      b_prev  <= b_s2;
      a_const <= a_const_n;
      b_const <= b_const_n;
      a_tog   <= a_tog_n;
      b_tog   <= b_tog_n;
      in_ph   <= in_n;
      anti_ph <= anti_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= UNLOCKED;
      cand     <= 2'd0;
      conf     <= 4'd0;
      inv      <= 4'd0;
      state_r  <= 2'd0;
      change_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      fsm      <= fsm_n;
      cand     <= cand_n;
      conf     <= conf_n;
      inv      <= inv_n;
      state_r  <= state_n;
      change_r <= change_n;
      err_r    <= err_n;
    end
  end

  assign conf_inc = (conf == 4'(CONFIRM)) ? conf : conf + 4'd1;

  always_comb begin
    fsm_n    = fsm;
    cand_n   = cand;
    conf_n   = conf;
    inv_n    = inv;
    state_n  = state_r;
    change_n = 1'b0;
    err_n    = 1'b0;
    if (win_done) begin
      if (cls_ok) begin
        if (cls == cand) begin
          conf_n = conf_inc;
        end else begin
          cand_n = cls;
          conf_n = 4'd1;
        end
        inv_n = 4'd0;
        if ((conf_n == 4'(CONFIRM)) && ((fsm == UNLOCKED) || (cls != state_r))) begin
          state_n  = cls;
          fsm_n    = LOCKED;
          change_n = 1'b1;
        end
      end else begin
        err_n  = 1'b1;
        conf_n = 4'd0;
        inv_n  = (inv == 4'(CONFIRM)) ? inv : inv + 4'd1;
        // Dropping lock keeps the last state visible but never pulses state_change
        if (inv_n == 4'(CONFIRM)) fsm_n = UNLOCKED;
      end
    end
  end

  assign bus.state        = state_r;
  assign bus.state_valid  = (fsm == LOCKED);
  assign bus.state_change = change_r;
  assign bus.pattern_err  = err_r;
  assign bus.locked_dbg   = (fsm == LOCKED);

endmodule
